// File: rtl/aes_pkg.sv
// Shared AES datapath types and constants used by the ciphertext drain stage.
package aes_pkg;

    localparam int AES_BLOCK_W         = 128;
    localparam int AES_WORD_W          = 32;
    localparam int AES_WORDS_PER_BLOCK = 4;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;
    typedef logic [AES_WORD_W-1:0]  aes_word_t;
    typedef logic [1:0]             aes_widx_t;

endpackage

// File: rtl/aes_cipher_drain_block_fifo.sv
// Circular block buffer: storage, read/write pointers, level and push/pop bookkeeping.
module aes_block_fifo
    import aes_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_req,
    input  logic                   pop,
    input  aes_block_t             din,
    output aes_block_t             head,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   push_ok
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW:0]   level_q, level_d;
    aes_block_t    mem_q [DEPTH];

    assign full    = (level_q == (PW+1)'(DEPTH));
    // A full buffer still accepts a block when the head block leaves on the same edge.
    assign push_ok = push_req & (~full | pop);
    assign head    = mem_q[rptr_q];
    assign level   = level_q;

    always_comb begin
        wptr_d  = wptr_q + PW'(push_ok);
        rptr_d  = rptr_q + PW'(pop);
        level_d = level_q;
        case ({push_ok, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= din;
        end
    end

endmodule

// File: rtl/aes_cipher_drain.sv
// AES ciphertext drain: buffers 128-bit blocks and streams them as 32-bit words.
// Optional build macro AES_DRAIN_BYTESWAP_EN byte-reverses each presented word.
module aes_cipher_drain
    import aes_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int WORD       = 32,
    parameter int DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    input  logic [DATA_WIDTH-1:0]  block_in,
    output logic [WORD-1:0]        word_out,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic                   word_last,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    function automatic aes_word_t byte_swap(input aes_word_t w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    aes_block_t head;
    aes_word_t  word_sel;
    aes_word_t  word_pres;
    aes_widx_t  widx_q, widx_d;
    logic       overflow_q, overflow_d;
    logic       full, push_ok, xfer, pop;

    aes_block_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_req (valid_in & ~rst),
        .pop      (pop),
        .din      (block_in),
        .head     (head),
        .level    (level),
        .full     (full),
        .push_ok  (push_ok)
    );

    assign word_valid = (level != '0);
    assign xfer       = word_valid & word_ready;
    assign pop        = xfer & (widx_q == 2'd3);
    assign word_last  = word_valid & (widx_q == 2'd3);

    // Most significant word leaves first.
    always_comb begin
        word_sel = '0;
        case (widx_q)
            2'd0:    word_sel = head[127:96];
            2'd1:    word_sel = head[95:64];
            2'd2:    word_sel = head[63:32];
            default: word_sel = head[31:0];
        endcase
    end

`ifdef AES_DRAIN_BYTESWAP_EN
    assign word_pres = byte_swap(word_sel);
`else
    assign word_pres = word_sel;
`endif

    assign word_out = word_valid ? word_pres : '0;

    always_comb begin
        widx_d     = xfer ? widx_q + 2'd1 : widx_q;
        overflow_d = overflow_q | (valid_in & ~push_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            widx_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            widx_q     <= widx_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

endmodule

// File: tb/tb_aes_cipher_drain.sv
// Directed, table-driven bench for aes_cipher_drain (either byte-order build).
module tb_aes_cipher_drain;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_in;
    logic [127:0] block_in;
    logic [31:0]  word_out;
    logic         word_valid;
    logic         word_ready;
    logic         word_last;
    logic [2:0]   level;
    logic         overflow;

    int n_cmp = 0;
    int n_bad = 0;

    aes_cipher_drain #(.DATA_WIDTH(128), .WORD(32), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .block_in   (block_in),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_last  (word_last),
        .level      (level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         vin;
        logic [127:0] blk;
        logic         rdy;
        logic         ewv;
        logic [31:0]  ew;
        logic         elast;
        logic [2:0]   elvl;
        logic         eov;
    } vec_t;

    vec_t tbl[$];

    localparam logic [127:0] B1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    logic [127:0] blks [6];

    function automatic logic [31:0] exp_w(input logic [31:0] w);
`ifdef AES_DRAIN_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic [31:0] wsel(input logic [127:0] b, input int i);
        logic [127:0] t;
        t = b << (32 * i);
        return exp_w(t[127:96]);
    endfunction

    function automatic vec_t mk(input logic vin, input logic [127:0] blk, input logic rdy,
                                input logic ewv, input logic [31:0] ew, input logic elast,
                                input logic [2:0] elvl, input logic eov);
        vec_t v;
        v.vin = vin; v.blk = blk; v.rdy = rdy; v.ewv = ewv; v.ew = ew;
        v.elast = elast; v.elvl = elvl; v.eov = eov;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic chk_all(input string tag, input logic ewv, input logic [31:0] ew,
                           input logic elast, input logic [2:0] elvl, input logic eov);
        chk({tag, ".word_valid"}, 32'(word_valid), 32'(ewv));
        chk({tag, ".word_out"},   word_out,        ew);
        chk({tag, ".word_last"},  32'(word_last),  32'(elast));
        chk({tag, ".level"},      32'(level),      32'(elvl));
        chk({tag, ".overflow"},   32'(overflow),   32'(eov));
    endtask

    // Drive inputs, take one edge, sample shortly after it.
    task automatic cyc(input logic r, input logic vin, input logic [127:0] blk, input logic rdy);
        rst = r; valid_in = vin; block_in = blk; word_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        blks[0] = B1;
        blks[1] = 128'h11111111_22222222_33333333_44444444;
        blks[2] = 128'ha0a0a0a1_a0a0a0a2_a0a0a0a3_a0a0a0a4;
        blks[3] = 128'hb0b0b0b1_b0b0b0b2_b0b0b0b3_b0b0b0b4;
        blks[4] = 128'hc0c0c0c1_c0c0c0c2_c0c0c0c3_c0c0c0c4;
        blks[5] = 128'hdeadbeef_01234567_89abcdef_fedcba98;

        // Single block, ready held high.
        tbl.push_back(mk(1, B1, 1, 1, wsel(B1, 0), 0, 1, 0));
        tbl.push_back(mk(0, '0, 1, 1, wsel(B1, 1), 0, 1, 0));
        tbl.push_back(mk(0, '0, 1, 1, wsel(B1, 2), 0, 1, 0));
        tbl.push_back(mk(0, '0, 1, 1, wsel(B1, 3), 1, 1, 0));
        tbl.push_back(mk(0, '0, 1, 0, 32'h0, 0, 0, 0));
        // Backpressure after word 1.
        tbl.push_back(mk(1, B1, 0, 1, wsel(B1, 0), 0, 1, 0));
        tbl.push_back(mk(0, '0, 1, 1, wsel(B1, 1), 0, 1, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, '0, 0, 1, wsel(B1, 1), 0, 1, 0));
        tbl.push_back(mk(0, '0, 1, 1, wsel(B1, 2), 0, 1, 0));
        tbl.push_back(mk(0, '0, 1, 1, wsel(B1, 3), 1, 1, 0));
        tbl.push_back(mk(0, '0, 1, 0, 32'h0, 0, 0, 0));
        // Fill with five blocks; the fifth is dropped.
        for (int i = 1; i <= 5; i++)
            tbl.push_back(mk(1, blks[i], 0, 1, wsel(blks[1], 0), 0,
                             3'((i > 4) ? 4 : i), (i == 5)));
        // Drain blocks 1..4 of the burst; overflow stays sticky.
        for (int k = 1; k <= 16; k++) begin
            if (k == 16)
                tbl.push_back(mk(0, '0, 1, 0, 32'h0, 0, 0, 1));
            else
                tbl.push_back(mk(0, '0, 1, 1, wsel(blks[1 + k/4], k%4), (k%4 == 3),
                                 3'(4 - k/4), 1));
        end

        rst = 1; valid_in = 0; block_in = '0; word_ready = 0;
        cyc(1, 0, '0, 0);
        cyc(1, 1, B1, 1);
        chk_all("reset", 0, 32'h0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(0, tbl[i].vin, tbl[i].blk, tbl[i].rdy);
            chk_all($sformatf("vec%0d", i), tbl[i].ewv, tbl[i].ew, tbl[i].elast,
                    tbl[i].elvl, tbl[i].eov);
        end

        // Reset clears sticky overflow; valid_in during reset is ignored.
        cyc(1, 1, blks[5], 0);
        chk_all("rst_clr", 0, 32'h0, 0, 0, 0);

        // Full buffer: push lands on the same edge as the word-3 transfer.
        for (int i = 1; i <= 4; i++) cyc(0, 1, blks[i], 0);
        chk_all("full4", 1, wsel(blks[1], 0), 0, 4, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, '0, 1);
        chk_all("full_w3", 1, wsel(blks[1], 3), 1, 4, 0);
        cyc(0, 1, blks[5], 1);
        chk_all("pushpop", 1, wsel(blks[2], 0), 0, 4, 0);
        for (int k = 1; k <= 16; k++) begin
            cyc(0, 0, '0, 1);
            if (k == 16)
                chk_all("pp_end", 0, 32'h0, 0, 0, 0);
            else
                chk_all($sformatf("pp%0d", k), 1, wsel(blks[2 + k/4], k%4), (k%4 == 3),
                        3'(4 - k/4), 0);
        end

        // Reset mid-drain with three blocks held.
        for (int i = 1; i <= 3; i++) cyc(0, 1, blks[i], 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, '0, 1);
        chk_all("pre_rst", 1, wsel(blks[1], 3), 1, 3, 0);
        cyc(1, 0, '0, 1);
        chk_all("mid_rst", 0, 32'h0, 0, 0, 0);
        cyc(0, 1, B1, 0);
        chk_all("post_rst", 1, wsel(B1, 0), 0, 1, 0);
        cyc(0, 0, '0, 1);
        chk_all("post_rst_w1", 1, wsel(B1, 1), 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
